sram_write_arbiter: RTL
=======================

# sram_write_arbiter

Shares the co-processor's single SRAM write port between up to N_REQ store requesters (per-lane register write-back units). The arbiter picks one requester at a time by round-robin, latches its address and operand, and drives the SRAM write strobe for a fixed WRITE_CYCLES window. At the end of the window it signals completion with the winner's index. It sits between the execution lanes and the SRAM write port and is the only block that drives the SRAM write address, data and enable.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, SRAM address width
- DATA_W, 32, operand width
- WRITE_CYCLES, 2, cycles w_en is held per write (1..15)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en  in  1  arbitration enable; low blocks new grants, an in-flight write still completes
- req  in  N_REQ  per-requester write request; level, held until granted
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i belongs to req[i]
- req_data  in  N_REQ*DATA_W  packed operands; slice i belongs to req[i]
- grant  out  N_REQ  one-hot, single-cycle acknowledge
- sram_addr  out  ADDR_W  SRAM write address
- sram_data  out  DATA_W  SRAM write data
- w_en  out  1  SRAM write enable
- done  out  1  single-cycle pulse on the last write cycle
- done_id  out  max(1,clog2(N_REQ))  index of the completing requester, valid when done=1
- busy  out  1  high while in WRITE

## Operation
- Two states: IDLE and WRITE. A cycle counter (4 bits) and a last-winner pointer `ptr` (clog2 bits) are held.
- Arbitration point: every cycle in IDLE, and the last WRITE cycle (counter == WRITE_CYCLES-1). Arbitration occurs only when en=1.
- Eligible set: req, with the requester whose grant is high in the current cycle masked out. This prevents a double grant when WRITE_CYCLES=1.
- Winner: the first eligible index searching ptr+1, ptr+2, … with wrap at N_REQ.
- On a win, at the next edge:
  - the state becomes WRITE and the counter is set to 0;
  - sram_addr and sram_data take the winner's slices;
  - grant[winner]=1 for that one cycle;
  - ptr=winner.
- In WRITE:
  - w_en=1 and busy=1;
  - sram_addr and sram_data are held stable; changes on req_addr/req_data are ignored;
  - the counter increments each cycle.
- Last WRITE cycle: done=1 and done_id=latched winner. The next state is WRITE (new winner) if arbitration succeeds, otherwise IDLE.
- Returning to IDLE: w_en=0. sram_addr and sram_data keep their last values.
- Requesters must drop or replace req/data in the cycle after their grant. The arbiter never grants the same requester in two consecutive cycles.
- Unused or out-of-range requests are ignored: N_REQ fixes the vector width.

## Timing
- Reset values:
  - outputs: grant=0, sram_addr=0, sram_data=0, w_en=0, done=0, done_id=0, busy=0;
  - internal: state=IDLE, counter=0, ptr=N_REQ-1, so requester 0 wins first.
- Latency: req sampled high at edge k in IDLE gives grant, w_en and a valid address/data during cycle k+1.
- w_en stays high for exactly WRITE_CYCLES cycles per grant. done is high in the last of those cycles.
- Back-to-back throughput: with continuous eligible requests, w_en stays high with no bubble. A new grant coincides with the first cycle of the next window.
- Simultaneous req on several lines: exactly one grant, chosen by rotation. No requester waits more than N_REQ-1 windows.
- en falling mid-WRITE: the current window runs to completion with done asserted, then the state goes to IDLE.
- rst asserted mid-WRITE: immediate return to reset values. No done is issued for the aborted write, and the requester must re-request.

## Test plan
- Single request (WRITE_CYCLES=2): req[2]=1, addr 0x1A, data 0x3F800000 -> the next cycle has grant=0100, w_en high for 2 cycles with sram_addr=0x1A and sram_data=0x3F800000, then done=1 with done_id=2 in the second cycle.
- All four requesting continuously from reset -> grant order 0,1,2,3,0. w_en is continuously high for 8 cycles per round, with done pulses every 2 cycles.
- WRITE_CYCLES=1, req[1] held high one cycle past its grant -> exactly one grant to requester 1. No double write occurs, and the port goes to IDLE.
- en dropped in the first WRITE cycle while req[3] is pending -> the current write completes with done pulsed, then the block goes to IDLE with no grant[3] until en=1.
- rst pulsed during the second WRITE cycle -> all outputs are 0 asynchronously and no done is issued. After release, with req=1111, the first grant goes to requester 0.
- Data stability: req_data[0] changed during WRITE -> sram_data keeps the value latched at grant for the whole window.

Source files
------------

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter sharing one SRAM write port between N_REQ store requesters.
// A winner's address/data are latched at grant and written for WRITE_CYCLES cycles.
module sram_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int WRITE_CYCLES = 2,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_data,
  output logic                      w_en,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic                      busy
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WRITE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   win_nxt;
  logic [N_REQ-1:0]  eligible;
  logic              last;
  logic              arb;
  logic              found;
  int                idx;

  assign last = (state == S_WRITE) && (cnt == LAST_CNT);
  assign arb  = en && ((state == S_IDLE) || last);

  // Masking the live grant keeps a WRITE_CYCLES=1 requester from winning twice in a row.
  assign eligible = req & ~grant;

  always_comb begin
    found   = 1'b0;
    win_nxt = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_nxt = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (arb && found) begin
      state_nxt = S_WRITE;
      cnt_nxt   = '0;
    end else if (state == S_WRITE) begin
      if (last) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= ID_W'(N_REQ - 1);
      win_id    <= '0;
      grant     <= '0;
      sram_addr <= '0;
      sram_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      grant <= '0;
      if (arb && found) begin
        grant     <= N_REQ'(1) << win_nxt;
        ptr       <= win_nxt;
        win_id    <= win_nxt;
        sram_addr <= req_addr[int'(win_nxt)*ADDR_W +: ADDR_W];
        sram_data <= req_data[int'(win_nxt)*DATA_W +: DATA_W];
      end
    end
  end

  assign w_en    = (state == S_WRITE);
  assign busy    = (state == S_WRITE);
  assign done    = last;
  assign done_id = last ? win_id : '0;

endmodule
